// File: rtl/rd_arb_pkg.sv
// Shared types and sizing for the two-requester read-channel arbiter.
package rd_arb_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_arb_state_t;

    localparam int NREQ   = 2;
    localparam int BLEN_W = 4;

    // Burst field carries length minus one; widen by a bit so 16 beats fits.
    function automatic logic [BLEN_W:0] burst_beats(input logic [BLEN_W-1:0] arburst);
        return {1'b0, arburst} + {{BLEN_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
    import rd_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last_grant,
    output logic            winner
);

    always_comb begin
        // NOTE: default first, so no input combination leaves winner unassigned and infers a latch.
        winner = last_grant;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = last_grant;
        endcase
    end

endmodule

// File: rtl/rd_arbiter.sv
// Shares one external read port between the weight-buffer address generator (m0) and the
// feature-map buffer (m1), one burst at a time, with beat-count protocol checking.
module rd_arbiter
    import rd_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     m0_araddr,
    input  logic              m0_arvalid,
    input  logic [BLEN_W-1:0] m0_arburst,
    output logic              m0_arready,
    output logic [DW-1:0]     m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_rlast,
    input  logic [AW-1:0]     m1_araddr,
    input  logic              m1_arvalid,
    input  logic [BLEN_W-1:0] m1_arburst,
    output logic              m1_arready,
    output logic [DW-1:0]     m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_rlast,
    output logic [AW-1:0]     s_araddr,
    output logic              s_arvalid,
    output logic [BLEN_W-1:0] s_arburst,
    input  logic              s_arready,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_rvalid,
    input  logic              s_rlast,
    output logic              grant,
    output logic              busy,
    output logic              err
);

    rd_arb_state_t     state;
    logic              last_grant;
    logic [BLEN_W:0]   exp_beats;
    logic [BLEN_W:0]   beat_cnt;
    logic [BLEN_W:0]   cnt_next;
    logic [NREQ-1:0]   req;
    logic              winner;
    logic              gnt_arvalid;
    logic [AW-1:0]     gnt_araddr;
    logic [BLEN_W-1:0] gnt_arburst;

    assign req = {m1_arvalid, m0_arvalid};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign gnt_arvalid = grant ? m1_arvalid : m0_arvalid;
    assign gnt_araddr  = grant ? m1_araddr  : m0_araddr;
    assign gnt_arburst = grant ? m1_arburst : m0_arburst;
    assign cnt_next    = beat_cnt + {{BLEN_W{1'b0}}, 1'b1};

    // The shared address channel is driven only while a grant is in its address phase.
    assign s_arvalid = (state == ADDR) & gnt_arvalid;
    assign s_araddr  = (state == ADDR) ? gnt_araddr  : '0;
    assign s_arburst = (state == ADDR) ? gnt_arburst : '0;

    assign m0_arready = (state == ADDR) & s_arready & ~grant;
    assign m1_arready = (state == ADDR) & s_arready &  grant;
    assign m0_rvalid  = (state == DATA) & s_rvalid  & ~grant;
    assign m1_rvalid  = (state == DATA) & s_rvalid  &  grant;
    assign m0_rlast   = (state == DATA) & s_rlast   & ~grant;
    assign m1_rlast   = (state == DATA) & s_rlast   &  grant;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign busy       = (state != IDLE);

    // NOTE: non-blocking assignments so every register updates from the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            exp_beats  <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_rvalid) err <= 1'b1;
                    if (|req) begin
                        grant <= winner;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_rvalid) err <= 1'b1;
                    // A requester withdrawing mid-handshake forfeits its turn without updating fairness.
                    if (!gnt_arvalid) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (s_arready) begin
                        exp_beats <= burst_beats(gnt_arburst);
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid) begin
                        beat_cnt <= cnt_next;
                        if (s_rlast) begin
                            if (cnt_next != exp_beats) err <= 1'b1;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else if (cnt_next == exp_beats) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_arbiter.sv
// Self-checking bench for rd_arbiter: directed scenarios plus a randomized run against a
// burst-level reference model of the round-robin read port.
module tb_rd_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [3:0]    m0_arburst, m1_arburst, s_arburst;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic          s_arvalid, s_arready, s_rvalid, s_rlast;
    logic          grant, busy, err;

    int total = 0;
    int bad   = 0;

    rd_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arburst (m0_arburst),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rvalid  (m0_rvalid),
        .m0_rlast   (m0_rlast),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arburst (m1_arburst),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rvalid  (m1_rvalid),
        .m1_rlast   (m1_rlast),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arburst  (s_arburst),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rvalid   (s_rvalid),
        .s_rlast    (s_rlast),
        .grant      (grant),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_araddr = '0; m0_arvalid = 1'b0; m0_arburst = '0;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_arburst = '0;
        s_arready = 1'b0; s_rdata = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"},  grant,      0);
        check({tag, "_busy"},   busy,       0);
        check({tag, "_err"},    err,        0);
        check({tag, "_sarv"},   s_arvalid,  0);
        check({tag, "_saddr"},  s_araddr,   0);
        check({tag, "_sburst"}, s_arburst,  0);
        check({tag, "_ar0"},    m0_arready, 0);
        check({tag, "_ar1"},    m1_arready, 0);
        check({tag, "_rv0"},    m0_rvalid,  0);
        check({tag, "_rv1"},    m1_rvalid,  0);
        check({tag, "_rl0"},    m0_rlast,   0);
        check({tag, "_rl1"},    m1_rlast,   0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_quiet(tag);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Returns at the negedge of the first cycle showing s_arvalid; waited counts the cycles before it.
    task automatic wait_ar(input string tag, output int waited);
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_arvalid) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic send_beats(input int owner, input int n, input int last_at, input string tag);
        logic [DW-1:0] d;
        for (int i = 1; i <= n; i++) begin
            d = $urandom;
            s_rvalid = 1'b1;
            s_rlast  = (i == last_at);
            s_rdata  = d;
            @(negedge clk);
            check({tag, "_rv_own"}, (owner != 0) ? m1_rvalid : m0_rvalid, 1);
            check({tag, "_rv_oth"}, (owner != 0) ? m0_rvalid : m1_rvalid, 0);
            check({tag, "_rlast"},  (owner != 0) ? m1_rlast  : m0_rlast,  (i == last_at) ? 1 : 0);
            check({tag, "_rdata"},  (owner != 0) ? m1_rdata  : m0_rdata,  d);
            check({tag, "_arrdy"},  {m1_arready, m0_arready}, 0);
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    // Random-run reference state: a burst-level view of who owns the port and what it asked for.
    logic [1:0]    pend;
    logic [AW-1:0] raddr [2];
    logic [3:0]    rburst [2];
    int            phase;
    bit            owner, lastg;
    int            left, got, exp_n;

    initial begin
        int w;
        idle_inputs();
        do_reset("rst");

        // m0 alone, 9-beat burst; m1 arrives during m0's data phase.
        m0_araddr = 32'h1000; m0_arburst = 4'd8; m0_arvalid = 1'b1; s_arready = 1'b1;
        @(negedge clk);
        check("t1_ar_idle", s_arvalid, 0);
        wait_ar("t1_ar", w);
        check("t1_ar_lat", w, 0);
        check("t1_addr",  s_araddr,   32'h1000);
        check("t1_burst", s_arburst,  8);
        check("t1_ar0",   m0_arready, 1);
        check("t1_ar1",   m1_arready, 0);
        check("t1_grant", grant,      0);
        check("t1_busy",  busy,       1);
        tick();
        m0_arvalid = 1'b0;
        m1_araddr = 32'h2000; m1_arburst = 4'd1; m1_arvalid = 1'b1;
        send_beats(0, 9, 9, "t1");
        wait_ar("t3_ar", w);
        check("t3_ar_lat", w, 1);
        check("t3_grant", grant,      1);
        check("t3_addr",  s_araddr,   32'h2000);
        check("t3_ar1",   m1_arready, 1);
        check("t3_ar0",   m0_arready, 0);
        check("t1_err",   err,        0);
        tick();
        m1_arvalid = 1'b0;
        send_beats(1, 2, 2, "t3");
        @(negedge clk);
        check("t3_err",  err,  0);
        check("t3_busy", busy, 0);
        tick();

        // Both requesting from reset: strict alternation starting with m0.
        do_reset("rst2");
        m0_araddr = 32'hA0; m1_araddr = 32'hB0; m0_arburst = '0; m1_arburst = '0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_ar("t2_ar", w);
            check("t2_grant", grant, j % 2);
            check("t2_addr", s_araddr, (j % 2 != 0) ? 32'hB0 : 32'hA0);
            tick();
            send_beats(j % 2, 1, 1, "t2");
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;

        // Early rlast: error is sticky through a later clean burst.
        m0_arburst = 4'd3; m0_arvalid = 1'b1;
        wait_ar("t4_ar", w);
        check("t4_grant", grant, 0);
        tick();
        m0_arvalid = 1'b0;
        send_beats(0, 2, 2, "t4");
        @(negedge clk);
        check("t4_err",  err,  1);
        check("t4_busy", busy, 0);
        tick();
        m1_arburst = 4'd0; m1_arvalid = 1'b1;
        wait_ar("t4b_ar", w);
        tick();
        m1_arvalid = 1'b0;
        send_beats(1, 1, 1, "t4b");
        @(negedge clk);
        check("t4_err_sticky", err, 1);
        tick();

        // Granted requester withdraws before the handshake: error, fairness pointer untouched.
        do_reset("rst3");
        m0_arvalid = 1'b1; s_arready = 1'b0;
        wait_ar("td_ar", w);
        tick();
        m0_arvalid = 1'b0;
        @(negedge clk);
        check("td_sarv", s_arvalid, 0);
        tick();
        @(negedge clk);
        check("td_err",  err,  1);
        check("td_busy", busy, 0);
        tick();
        m0_arburst = '0; m1_arburst = '0; m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        wait_ar("td_tie", w);
        check("td_tie_grant", grant, 0);
        s_arready = 1'b1;
        tick();
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        send_beats(0, 1, 1, "td");

        // Stray beat in IDLE, then reset mid-burst.
        do_reset("rst4");
        s_rvalid = 1'b1;
        @(negedge clk);
        check("t5_idle_rv", {m1_rvalid, m0_rvalid}, 0);
        tick();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("t5_idle_err", err, 1);
        tick();
        m1_arburst = 4'd3; m1_arvalid = 1'b1; s_arready = 1'b1;
        wait_ar("t5_ar", w);
        tick();
        m1_arvalid = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h5A5A;
        @(negedge clk);
        check("t5_rv1", m1_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("t5_async");
        s_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_rel_grant", grant, 0);
        check("t5_rel_err",   err,   0);
        tick();
        s_rvalid = 1'b1;
        @(negedge clk);
        check("t5_stray_rv", m1_rvalid, 0);
        tick();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("t5_stray_err", err, 1);
        tick();

        // Randomized traffic against the burst-level model.
        do_reset("rst5");
        pend = '0; phase = 0; lastg = 1'b1; owner = 1'b0; left = 0; got = 0; exp_n = 0;
        raddr[0] = '0; raddr[1] = '0; rburst[0] = '0; rburst[1] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k]   = 1'b1;
                    raddr[k]  = $urandom;
                    rburst[k] = 4'($urandom_range(0, 15));
                end
            end
            m0_arvalid = pend[0]; m0_araddr = raddr[0]; m0_arburst = rburst[0];
            m1_arvalid = pend[1]; m1_araddr = raddr[1]; m1_arburst = rburst[1];
            s_arready = 1'($urandom_range(0, 1));
            s_rdata   = $urandom;
            s_rvalid  = (phase == 2) && ($urandom_range(0, 2) != 0);
            s_rlast   = s_rvalid && (left == 1);
            @(negedge clk);
            check("r_busy", busy, (phase != 0) ? 1 : 0);
            check("r_sarv", s_arvalid, (phase == 1) ? 1 : 0);
            check("r_ar0", m0_arready, (phase == 1 && owner == 1'b0 && s_arready) ? 1 : 0);
            check("r_ar1", m1_arready, (phase == 1 && owner == 1'b1 && s_arready) ? 1 : 0);
            check("r_rv0", m0_rvalid, (phase == 2 && owner == 1'b0 && s_rvalid) ? 1 : 0);
            check("r_rv1", m1_rvalid, (phase == 2 && owner == 1'b1 && s_rvalid) ? 1 : 0);
            check("r_rl0", m0_rlast, (phase == 2 && owner == 1'b0 && s_rlast) ? 1 : 0);
            check("r_rl1", m1_rlast, (phase == 2 && owner == 1'b1 && s_rlast) ? 1 : 0);
            check("r_err", err, 0);
            if (phase != 0) check("r_grant", grant, owner);
            if (phase == 1) begin
                check("r_addr",  s_araddr,  raddr[owner]);
                check("r_burst", s_arburst, rburst[owner]);
            end
            if (phase == 2 && s_rvalid)
                check("r_rdata", owner ? m1_rdata : m0_rdata, s_rdata);
            case (phase)
                0: if (pend != 2'b00) begin
                    owner = (pend == 2'b11) ? ~lastg : pend[1];
                    phase = 1;
                end
                1: if (s_arready) begin
                    exp_n = int'(rburst[owner]) + 1;
                    left  = exp_n;
                    got   = 0;
                    pend[owner] = 1'b0;
                    phase = 2;
                end
                default: if (s_rvalid) begin
                    got  += (owner ? int'(m1_rvalid) : int'(m0_rvalid));
                    left -= 1;
                    if (left == 0) begin
                        check("r_beats", got, exp_n);
                        lastg = owner;
                        phase = 0;
                    end
                end
            endcase
            tick();
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
